// File: rtl/ctrl_seq_pkg.sv
// Shared opcodes, select codes, ALU codes, state type and legality helpers for ctrl_sequencer.
// Optional LDI support is enabled by defining CTRL_SEQ_LDI_EN.
package ctrl_seq_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_MOV  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_LDI  = 3'd6;

  localparam int SEL_NONE = 0;
  localparam int SEL_EXT  = 1;
  localparam int SEL_G    = 2;
  localparam int SEL_A    = 3;
  localparam int SEL_IMM  = 4;
  localparam int SEL_R0   = 5;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;

  typedef enum logic [2:0] {IDLE, EX1, ALU_A, ALU_OP, ALU_WB} state_t;

  // Only fields the opcode actually uses are range-checked.
  function automatic logic is_illegal(logic [2:0] op, logic [3:0] rd, logic [3:0] rs,
                                      int num_regs);
    logic rd_bad;
    logic rs_bad;
    rd_bad = int'(rd) >= num_regs;
    rs_bad = int'(rs) >= num_regs;
    case (op)
      OP_NOP:                          return 1'b0;
      OP_LOAD:                         return rd_bad;
      OP_MOV, OP_ADD, OP_SUB, OP_AND:  return rd_bad | rs_bad;
`ifdef CTRL_SEQ_LDI_EN
      OP_LDI:                          return rd_bad;
`else
      OP_LDI:                          return 1'b1;
`endif
      default:                         return 1'b1;
    endcase
  endfunction

  function automatic state_t first_state(logic [2:0] op, logic [3:0] rd, logic [3:0] rs,
                                         int num_regs);
    if (!is_illegal(op, rd, rs, num_regs) && (op == OP_ADD || op == OP_SUB || op == OP_AND))
      return ALU_A;
    return EX1;
  endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// Combinational control decode from sequencer state and latched instruction.
// LDI decode exists only when CTRL_SEQ_LDI_EN is defined.
module ctrl_seq_decode
  import ctrl_seq_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = $clog2(NUM_REGS + 5)
) (
  input  state_t            state,
  input  logic [22:0]       instr_q,
  output logic [SEL_W-1:0]  bus_sel,
  output logic [SEL_W-1:0]  ld_sel,
  output logic [1:0]        alu_op,
  output logic [11:0]       imm_out,
  output logic              pc_step,
  output logic              illegal
);

  logic [2:0] op;
  logic [3:0] rd;
  logic [3:0] rs;

  assign op = instr_q[22:20];
  assign rd = instr_q[19:16];
  assign rs = instr_q[15:12];

`ifndef CTRL_SEQ_LDI_EN
  logic unused_imm;
  assign unused_imm = ^instr_q[11:0];
`endif

  function automatic logic [SEL_W-1:0] sel(int code);
    return SEL_W'(code);
  endfunction

  always_comb begin
    bus_sel = '0;
    ld_sel  = '0;
    alu_op  = ALU_ADD;
    imm_out = '0;
    pc_step = 1'b0;
    illegal = 1'b0;
    case (state)
      EX1: begin
        pc_step = 1'b1;
        if (is_illegal(op, rd, rs, NUM_REGS)) begin
          illegal = 1'b1;
        end else begin
          case (op)
            OP_LOAD: begin
              bus_sel = sel(SEL_EXT);
              ld_sel  = sel(SEL_R0 + int'(rd));
            end
            OP_MOV: begin
              bus_sel = sel(SEL_R0 + int'(rs));
              ld_sel  = sel(SEL_R0 + int'(rd));
            end
`ifdef CTRL_SEQ_LDI_EN
            OP_LDI: begin
              bus_sel = sel(SEL_IMM);
              imm_out = instr_q[11:0];
              ld_sel  = sel(SEL_R0 + int'(rd));
            end
`endif
            default: ;
          endcase
        end
      end
      ALU_A: begin
        bus_sel = sel(SEL_R0 + int'(rd));
        ld_sel  = sel(SEL_A);
      end
      ALU_OP: begin
        bus_sel = sel(SEL_R0 + int'(rs));
        ld_sel  = sel(SEL_G);
        case (op)
          OP_SUB:  alu_op = ALU_SUB;
          OP_AND:  alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      ALU_WB: begin
        bus_sel = sel(SEL_G);
        ld_sel  = sel(SEL_R0 + int'(rd));
        pc_step = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: instruction handshake, state register and instruction latch.
// Define CTRL_SEQ_LDI_EN to enable the LDI (op 110) instruction.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int INSTR_W  = 23,
  parameter int SEL_W    = $clog2(NUM_REGS + 5)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [SEL_W-1:0]   bus_sel,
  output logic [SEL_W-1:0]   ld_sel,
  output logic [1:0]         alu_op,
  output logic [11:0]        imm_out,
  output logic               pc_step,
  output logic               illegal,
  output state_t             state_dbg
);

  state_t            state;
  state_t            state_nxt;
  logic [22:0]       instr_q;
  logic              final_cyc;
  logic              accept;
  logic [SEL_W-1:0]  dec_bus_sel;
  logic [SEL_W-1:0]  dec_ld_sel;
  logic [1:0]        dec_alu_op;
  logic [11:0]       dec_imm_out;
  logic              dec_pc_step;
  logic              dec_illegal;

  // Handshake: instr is taken on any rising edge where instr_valid & instr_ready;
  // ready is high in IDLE and in an instruction's final cycle, and the source
  // holds instr stable until it is taken. Valid while not ready is ignored.
  assign final_cyc   = (state == EX1) || (state == ALU_WB);
  assign instr_ready = !rst && ((state == IDLE) || final_cyc);
  assign accept      = instr_valid && instr_ready;
  assign state_dbg   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      instr_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) instr_q <= instr[22:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (accept) state_nxt = first_state(instr[22:20], instr[19:16], instr[15:12], NUM_REGS);
      EX1, ALU_WB: state_nxt = accept ? first_state(instr[22:20], instr[19:16], instr[15:12], NUM_REGS)
                                      : IDLE;
      ALU_A:       state_nxt = ALU_OP;
      ALU_OP:      state_nxt = ALU_WB;
      default:     state_nxt = IDLE;
    endcase
  end

  ctrl_seq_decode #(
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W)
  ) u_decode (
    .state   (state),
    .instr_q (instr_q),
    .bus_sel (dec_bus_sel),
    .ld_sel  (dec_ld_sel),
    .alu_op  (dec_alu_op),
    .imm_out (dec_imm_out),
    .pc_step (dec_pc_step),
    .illegal (dec_illegal)
  );

  // Reset silences every control output in the same cycle, so an abandoned
  // instruction can never issue a further load or PC step.
  assign bus_sel = rst ? '0 : dec_bus_sel;
  assign ld_sel  = rst ? '0 : dec_ld_sel;
  assign alu_op  = rst ? '0 : dec_alu_op;
  assign imm_out = rst ? '0 : dec_imm_out;
  assign pc_step = rst ? 1'b0 : dec_pc_step;
  assign illegal = rst ? 1'b0 : dec_illegal;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed per-cycle table plus randomized stream vs a reference model.
// Expectations for op 110 follow CTRL_SEQ_LDI_EN.
module tb_ctrl_sequencer;
  import ctrl_seq_pkg::*;

  localparam int NUM_REGS = 8;
  localparam int INSTR_W  = 23;
  localparam int SEL_W    = 4;
  localparam int W        = 25;
  localparam int NV       = 16;
  localparam int N_RAND   = 3000;
`ifdef CTRL_SEQ_LDI_EN
  localparam bit LDI_EN = 1'b1;
`else
  localparam bit LDI_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [INSTR_W-1:0] instr = '0;
  logic               instr_valid = 1'b0;
  logic               instr_ready;
  logic [SEL_W-1:0]   bus_sel;
  logic [SEL_W-1:0]   ld_sel;
  logic [1:0]         alu_op;
  logic [11:0]        imm_out;
  logic               pc_step;
  logic               illegal;
  state_t             state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  ctrl_sequencer #(
    .NUM_REGS (NUM_REGS),
    .INSTR_W  (INSTR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .bus_sel     (bus_sel),
    .ld_sel      (ld_sel),
    .alu_op      (alu_op),
    .imm_out     (imm_out),
    .pc_step     (pc_step),
    .illegal     (illegal),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  typedef struct {
    logic        rst;
    logic        valid;
    logic [22:0] instr;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[NV];

  function automatic logic [22:0] mk(int op, int rd, int rs, int imm);
    return {3'(op), 4'(rd), 4'(rs), 12'(imm)};
  endfunction

  // Record layout: {ready, bus, ld, alu, imm, pc_step, illegal}
  function automatic logic [W-1:0] rec(int rdy, int bus, int ld, int alu, int imm, int pc, int ill);
    return {1'(rdy), 4'(bus), 4'(ld), 2'(alu), 12'(imm), 1'(pc), 1'(ill)};
  endfunction

  function automatic vec_t mkv(logic r, logic v, logic [22:0] ins, logic [W-1:0] e);
    vec_t t;
    t.rst = r;
    t.valid = v;
    t.instr = ins;
    t.exp = e;
    return t;
  endfunction

  function automatic logic [W-1:0] actual();
    return {instr_ready, bus_sel, ld_sel, alu_op, imm_out, pc_step, illegal};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual rdy=%0d bus=%0d ld=%0d alu=%0d imm=%h pc=%0d ill=%0d, required rdy=%0d bus=%0d ld=%0d alu=%0d imm=%h pc=%0d ill=%0d",
               name, act[24], act[23:20], act[19:16], act[15:14], act[13:2], act[1], act[0],
               exp[24], exp[23:20], exp[19:16], exp[15:14], exp[13:2], exp[1], exp[0]);
    end
  endtask

  // Reference model: the per-cycle control records an accepted instruction produces.
  function automatic void push_seq(logic [22:0] ins);
    int op, rd, rs, imm;
    bit legal;
    op  = int'(ins[22:20]);
    rd  = int'(ins[19:16]);
    rs  = int'(ins[15:12]);
    imm = int'(ins[11:0]);
    case (op)
      0:       legal = 1;
      1:       legal = rd < NUM_REGS;
      2, 3, 4, 5: legal = (rd < NUM_REGS) && (rs < NUM_REGS);
      6:       legal = LDI_EN && (rd < NUM_REGS);
      default: legal = 0;
    endcase
    if (!legal) begin
      exp_q.push_back(rec(1, 0, 0, 0, 0, 1, 1));
    end else if (op >= 3 && op <= 5) begin
      exp_q.push_back(rec(0, 5 + rd, 3, 0, 0, 0, 0));
      exp_q.push_back(rec(0, 5 + rs, 2, op - 3, 0, 0, 0));
      exp_q.push_back(rec(1, 2, 5 + rd, 0, 0, 1, 0));
    end else if (op == 0) begin
      exp_q.push_back(rec(1, 0, 0, 0, 0, 1, 0));
    end else if (op == 1) begin
      exp_q.push_back(rec(1, 1, 5 + rd, 0, 0, 1, 0));
    end else if (op == 2) begin
      exp_q.push_back(rec(1, 5 + rs, 5 + rd, 0, 0, 1, 0));
    end else begin
      exp_q.push_back(rec(1, 4, 5 + rd, 0, imm, 1, 0));
    end
  endfunction

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    logic [22:0] cur;
    logic [W-1:0] exp;
    logic [W-1:0] ldi_exp;
    bit pending;

    ldi_exp = LDI_EN ? rec(1, 4, 5, 0, 12'hABC, 1, 0) : rec(1, 0, 0, 0, 0, 1, 1);

    vecs[0]  = mkv(1, 1, mk(2, 3, 5, 0),     rec(0, 0, 0, 0, 0, 0, 0));
    vecs[1]  = mkv(1, 1, mk(2, 3, 5, 0),     rec(0, 0, 0, 0, 0, 0, 0));
    vecs[2]  = mkv(0, 1, mk(2, 3, 5, 0),     rec(1, 0, 0, 0, 0, 0, 0));
    vecs[3]  = mkv(0, 1, mk(1, 1, 0, 0),     rec(1, 10, 8, 0, 0, 1, 0));
    vecs[4]  = mkv(0, 1, mk(4, 2, 4, 0),     rec(1, 1, 6, 0, 0, 1, 0));
    vecs[5]  = mkv(0, 1, mk(7, 0, 0, 0),     rec(0, 7, 3, 0, 0, 0, 0));
    vecs[6]  = mkv(0, 1, mk(7, 0, 0, 0),     rec(0, 9, 2, 1, 0, 0, 0));
    vecs[7]  = mkv(0, 1, mk(7, 0, 0, 0),     rec(1, 2, 7, 0, 0, 1, 0));
    vecs[8]  = mkv(0, 1, mk(2, 8, 0, 0),     rec(1, 0, 0, 0, 0, 1, 1));
    vecs[9]  = mkv(0, 1, mk(6, 0, 0, 'hABC), rec(1, 0, 0, 0, 0, 1, 1));
    vecs[10] = mkv(0, 1, mk(3, 1, 2, 0),     ldi_exp);
    vecs[11] = mkv(0, 0, mk(0, 0, 0, 0),     rec(0, 6, 3, 0, 0, 0, 0));
    vecs[12] = mkv(0, 0, mk(0, 0, 0, 0),     rec(0, 7, 2, 0, 0, 0, 0));
    vecs[13] = mkv(1, 0, mk(0, 0, 0, 0),     rec(0, 0, 0, 0, 0, 0, 0));
    vecs[14] = mkv(0, 0, mk(0, 0, 0, 0),     rec(1, 0, 0, 0, 0, 0, 0));
    vecs[15] = mkv(0, 0, mk(0, 0, 0, 0),     rec(1, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      instr_valid = vecs[i].valid;
      instr       = vecs[i].instr;
      #1;
      check($sformatf("vec%0d", i), actual(), vecs[i].exp);
    end

    pending = 0;
    cur = '0;
    for (int c = 0; c < N_RAND; c++) begin
      @(negedge clk);
      if (!pending && $urandom_range(0, 3) != 0) begin
        cur = {3'($urandom_range(0, 7)), 4'($urandom_range(0, 9)),
               4'($urandom_range(0, 9)), 12'($urandom)};
        pending = 1;
      end
      instr_valid = pending;
      instr       = cur;
      #1;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : rec(1, 0, 0, 0, 0, 0, 0);
      check($sformatf("rand%0d", c), actual(), exp);
      if (pending && exp[24]) begin
        push_seq(cur);
        pending = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
